// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: sequences a BUFGCE enable from level-sensitive clock demand, with wake delay, idle hold-off and enabled-cycle count
// ports: clk/resetn (async active-low); req|force_on = demand; clr_count clears gated_cycles;
//        en -> clock_gate.en; ack = gated clock valid; state OFF/WAKE/ON/HOLD = 0..3; gated_cycles saturating
module clock_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             force_on,
  input  logic             clr_count,
  output logic             en,
  output logic             ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gated_cycles
);
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, HOLD = 2'd3} state_t;
  localparam logic [15:0] WAKE_LD = 16'(WAKE_CYCLES != 0 ? WAKE_CYCLES - 1 : 0);
  localparam logic [15:0] IDLE_LD = 16'(IDLE_CYCLES != 0 ? IDLE_CYCLES - 1 : 0);
  localparam state_t      WAKE_TO = WAKE_CYCLES != 0 ? WAKE : ON;
  // release target: HOLD keeps the clock running, OFF drops it at once
  localparam state_t      REL_TO  = IDLE_CYCLES != 0 ? HOLD : OFF;
  localparam logic        REL_RUN = IDLE_CYCLES != 0;
  state_t      cur, nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        en_nxt, ack_nxt, demand;
  assign demand = req | force_on;
  assign state  = cur;
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    en_nxt  = en;
    ack_nxt = ack;
    unique case (cur)
      OFF:
        if (demand) begin
          nxt     = WAKE_TO;
          cnt_nxt = WAKE_LD;
          en_nxt  = 1'b1;
          ack_nxt = WAKE_CYCLES == 0;
        end
      WAKE:
        if (cnt != 16'd0) cnt_nxt = cnt - 16'd1;
        else if (demand) begin
          nxt     = ON;
          ack_nxt = 1'b1;
        end else begin
          nxt     = REL_TO;
          cnt_nxt = IDLE_LD;
          en_nxt  = REL_RUN;
          ack_nxt = REL_RUN;
        end
      ON:
        if (!demand) begin
          nxt     = REL_TO;
          cnt_nxt = IDLE_LD;
          en_nxt  = REL_RUN;
          ack_nxt = REL_RUN;
        end
      HOLD:
        if (demand) nxt = ON;
        else if (cnt != 16'd0) cnt_nxt = cnt - 16'd1;
        else begin
          nxt     = OFF;
          en_nxt  = 1'b0;
          ack_nxt = 1'b0;
        end
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cur <= OFF;
      cnt <= '0;
      en  <= 1'b0;
      ack <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      en  <= en_nxt;
      ack <= ack_nxt;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) gated_cycles <= '0;
    else gated_cycles <= clr_count ? '0 : (en && !(&gated_cycles)) ? gated_cycles + 1'b1 : gated_cycles;
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: directed scoreboard bench over three clock_gate_ctrl builds
module tb_clock_gate_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        resetn;
  logic [2:0]  req, fo, clr, en, ack;
  logic [1:0]  st_a, st_b, st_c;
  logic [31:0] gc_a;
  logic [7:0]  gc_b;
  logic [3:0]  gc_c;
  int n_chk = 0, n_fail = 0;
  logic [3:0]  sb_q[$];
  string       tag_q[$];
  logic [31:0] exp_cnt[3];
  logic [31:0] maxv[3];
  logic [2:0]  prev_en;
  clock_gate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(4), .CNT_W(32)) dut_a (
    .clk(clk), .resetn(resetn), .req(req[0]), .force_on(fo[0]), .clr_count(clr[0]),
    .en(en[0]), .ack(ack[0]), .state(st_a), .gated_cycles(gc_a));
  clock_gate_ctrl #(.WAKE_CYCLES(0), .IDLE_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .resetn(resetn), .req(req[1]), .force_on(fo[1]), .clr_count(clr[1]),
    .en(en[1]), .ack(ack[1]), .state(st_b), .gated_cycles(gc_b));
  clock_gate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(4), .CNT_W(4)) dut_c (
    .clk(clk), .resetn(resetn), .req(req[2]), .force_on(fo[2]), .clr_count(clr[2]),
    .en(en[2]), .ack(ack[2]), .state(st_c), .gated_cycles(gc_c));
  function automatic logic [1:0] obs_st(input int d);
    return d == 0 ? st_a : d == 1 ? st_b : st_c;
  endfunction
  function automatic logic [31:0] obs_gc(input int d);
    return d == 0 ? gc_a : d == 1 ? {24'd0, gc_b} : {28'd0, gc_c};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      exp_cnt[d] = 32'd0;
      prev_en[d] = 1'b0;
      chk({tag, ".state"}, 32'(obs_st(d)), 32'd0);
      chk({tag, ".en"}, 32'(en[d]), 32'd0);
      chk({tag, ".ack"}, 32'(ack[d]), 32'd0);
      chk({tag, ".cnt"}, obs_gc(d), 32'd0);
    end
  endtask
  task automatic step(input int d, input logic r, input logic f, input logic c,
                      input logic [1:0] es, input logic ee, input logic ea, input string tag);
    logic [3:0] e;
    string t;
    req[d] = r;
    fo[d]  = f;
    clr[d] = c;
    sb_q.push_back({es, ee, ea});
    tag_q.push_back(tag);
    exp_cnt[d] = c ? 32'd0 : (prev_en[d] && exp_cnt[d] != maxv[d]) ? exp_cnt[d] + 32'd1 : exp_cnt[d];
    prev_en[d] = ee;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".state"}, 32'(obs_st(d)), 32'(e[3:2]));
    chk({t, ".en"}, 32'(en[d]), 32'(e[1]));
    chk({t, ".ack"}, 32'(ack[d]), 32'(e[0]));
    chk({t, ".cnt"}, obs_gc(d), exp_cnt[d]);
  endtask
  initial begin
    resetn = 1'b0;
    req = '0;
    fo = '0;
    clr = '0;
    maxv[0] = 32'hFFFF_FFFF;
    maxv[1] = 32'd255;
    maxv[2] = 32'd15;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    resetn = 1'b1;
    step(0, 0, 0, 0, 2'd0, 0, 0, "a_idle");
    step(0, 1, 0, 0, 2'd1, 1, 0, "a_wake0");
    step(0, 1, 0, 0, 2'd1, 1, 0, "a_wake1");
    step(0, 1, 0, 0, 2'd2, 1, 1, "a_ack");
    repeat (3) step(0, 1, 0, 0, 2'd2, 1, 1, "a_on");
    repeat (4) step(0, 0, 0, 0, 2'd3, 1, 1, "a_hold");
    step(0, 0, 0, 0, 2'd0, 0, 0, "a_off");
    step(0, 1, 0, 0, 2'd1, 1, 0, "a_w2");
    step(0, 1, 0, 0, 2'd1, 1, 0, "a_w2b");
    step(0, 1, 0, 0, 2'd2, 1, 1, "a_on2");
    repeat (2) step(0, 0, 0, 0, 2'd3, 1, 1, "a_gap_hold");
    repeat (2) step(0, 1, 0, 0, 2'd2, 1, 1, "a_gap_on");
    repeat (4) step(0, 0, 0, 0, 2'd3, 1, 1, "a_exp_hold");
    step(0, 1, 0, 0, 2'd2, 1, 1, "a_exp_win");
    repeat (4) step(0, 0, 0, 0, 2'd3, 1, 1, "a_rel_hold");
    step(0, 0, 0, 0, 2'd0, 0, 0, "a_rel_off");
    step(0, 1, 0, 0, 2'd1, 1, 0, "a_rewake");
    step(0, 0, 0, 0, 2'd1, 1, 0, "a_wake_ign");
    repeat (4) step(0, 0, 0, 0, 2'd3, 1, 1, "a_pulse_hold");
    step(0, 0, 0, 0, 2'd0, 0, 0, "a_pulse_off");
    step(0, 0, 1, 0, 2'd1, 1, 0, "a_fo_w0");
    step(0, 0, 1, 0, 2'd1, 1, 0, "a_fo_w1");
    step(0, 1, 1, 0, 2'd2, 1, 1, "a_fo_on");
    step(0, 0, 0, 0, 2'd3, 1, 1, "a_fo_hold");
    step(0, 0, 1, 0, 2'd2, 1, 1, "a_fo_back");
    repeat (4) step(0, 0, 0, 0, 2'd3, 1, 1, "a_fo_rel");
    step(0, 0, 0, 0, 2'd0, 0, 0, "a_fo_off");
    step(0, 0, 0, 1, 2'd0, 0, 0, "a_clr_off");
    step(1, 0, 0, 0, 2'd0, 0, 0, "b_idle");
    step(1, 1, 0, 0, 2'd2, 1, 1, "b_on");
    step(1, 1, 0, 0, 2'd2, 1, 1, "b_on2");
    step(1, 0, 0, 0, 2'd0, 0, 0, "b_off");
    step(1, 1, 0, 0, 2'd2, 1, 1, "b_reon");
    step(1, 0, 1, 0, 2'd2, 1, 1, "b_fo");
    step(1, 0, 0, 0, 2'd0, 0, 0, "b_off2");
    step(2, 0, 1, 0, 2'd1, 1, 0, "c_w0");
    step(2, 0, 1, 0, 2'd1, 1, 0, "c_w1");
    step(2, 0, 1, 0, 2'd2, 1, 1, "c_on");
    repeat (17) step(2, 0, 1, 0, 2'd2, 1, 1, "c_run");
    chk("c_sat", obs_gc(2), 32'd15);
    step(2, 0, 1, 1, 2'd2, 1, 1, "c_clr");
    step(2, 0, 1, 0, 2'd2, 1, 1, "c_resume");
    step(2, 0, 1, 0, 2'd2, 1, 1, "c_resume2");
    #3 resetn = 1'b0;
    #1 chk_reset("async_rst");
    resetn = 1'b1;
    step(2, 0, 1, 0, 2'd1, 1, 0, "c_rw0");
    step(2, 0, 1, 0, 2'd1, 1, 0, "c_rw1");
    step(2, 0, 1, 0, 2'd2, 1, 1, "c_ron");
    repeat (4) step(2, 0, 0, 0, 2'd3, 1, 1, "c_hold");
    step(2, 0, 0, 0, 2'd0, 0, 0, "c_off");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
